// File: rtl/cpu6_fetch.sv
// Instruction fetch front end: single-outstanding memory request, EX register with a
// one-entry skid buffer, and redirect handling for traps, mret and EX branches.
module cpu6_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        pcsrcE,
    input  logic [31:0] pcnextE,
    input  logic        excp_ena,
    input  logic [31:0] csr_mtvec,
    input  logic        mret_ena,
    input  logic [31:0] csr_mepc,
    input  logic        stallE,
    output logic [31:0] pcE,
    output logic [31:0] instrE,
    output logic        validE
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } stateT;

    stateT       state;
    stateT       stateNext;
    logic [31:0] fetchPc;
    logic [31:0] reqPc;

    logic        redirect;
    logic [31:0] redirectPc;
    logic        rspTake;
    logic        exBusy;
    logic        toSkid;
    logic        exFill;
    logic        grant;
    logic        reqOk;

    logic        skidVld_p0;
    logic [31:0] skidPc_p0;
    logic [31:0] skidInstr_p0;

    logic        vld_p1;
    logic [31:0] pc_p1;
    logic [31:0] instr_p1;

    always_comb begin
        redirect   = excp_ena | mret_ena | pcsrcE;
        redirectPc = excp_ena ? csr_mtvec : (mret_ena ? csr_mepc : pcnextE);

        // Only a response to a live WAIT request carries a usable instruction.
        rspTake = imem_rvalid & (state == WAIT) & ~redirect;
        exBusy  = vld_p1 & stallE;
        toSkid  = rspTake & exBusy;
        exFill  = ~redirect & ~exBusy & (skidVld_p0 | rspTake);

        // A response landing in the skid buffer this cycle must block a new request,
        // otherwise its reply could arrive with nowhere to go.
        reqOk = ~reset & ~skidVld_p0 & ~toSkid & ~redirect
              & ((state == IDLE) | imem_rvalid);
        grant = reqOk & imem_gnt;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (grant) stateNext = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) stateNext = grant ? WAIT : IDLE;
                else if (redirect) stateNext = DROP;
            end
            DROP: begin
                if (imem_rvalid) stateNext = grant ? WAIT : IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Fetch stage: request state and address generation
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            fetchPc <= RESET_PC;
        end else begin
            state <= stateNext;
            if (redirect) fetchPc <= redirectPc;
            else if (grant) fetchPc <= fetchPc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) reqPc <= fetchPc;
    end

    // Skid stage (p0): holds one response while EX is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            skidVld_p0 <= 1'b0;
        end else if (redirect) begin
            skidVld_p0 <= 1'b0;
        end else if (toSkid) begin
            skidVld_p0 <= 1'b1;
        end else if (!stallE) begin
            skidVld_p0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (toSkid) begin
            skidPc_p0    <= reqPc;
            skidInstr_p0 <= imem_rdata;
        end
    end

    // EX stage (p1): skid buffer drains ahead of any fresh response
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            pc_p1  <= 32'h0000_0000;
        end else if (redirect) begin
            vld_p1 <= 1'b0;
        end else if (!exBusy) begin
            vld_p1 <= skidVld_p0 | rspTake;
            if (exFill) pc_p1 <= skidVld_p0 ? skidPc_p0 : reqPc;
        end
    end

    always_ff @(posedge clk) begin
        if (exFill) instr_p1 <= skidVld_p0 ? skidInstr_p0 : imem_rdata;
    end

    assign imem_req  = reqOk;
    assign imem_addr = fetchPc;
    assign pcE       = pc_p1;
    assign instrE    = vld_p1 ? instr_p1 : NOP_INSTR;
    assign validE    = vld_p1;

endmodule

// File: tb/tb_cpu6_fetch.sv
// Bench for cpu6_fetch: directed scenarios with literal expectations, then a randomized
// run checked every cycle against an in-order instruction-stream model and memory model.
module tb_cpu6_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        pcsrcE;
    logic [31:0] pcnextE;
    logic        excp_ena;
    logic [31:0] csr_mtvec;
    logic        mret_ena;
    logic [31:0] csr_mepc;
    logic        stallE;
    logic [31:0] pcE;
    logic [31:0] instrE;
    logic        validE;

    cpu6_fetch #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .pcsrcE     (pcsrcE),
        .pcnextE    (pcnextE),
        .excp_ena   (excp_ena),
        .csr_mtvec  (csr_mtvec),
        .mret_ena   (mret_ena),
        .csr_mepc   (csr_mepc),
        .stallE     (stallE),
        .pcE        (pcE),
        .instrE     (instrE),
        .validE     (validE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nTotal = 0;
    int nPass  = 0;
    int consumed = 0;

    // Memory model: one pending response, delivered after a random latency.
    bit          pendValid = 1'b0;
    bit          pendStale = 1'b0;
    logic [31:0] pendAddr  = 32'h0;
    int          pendDelay = 0;
    int          latMin = 0;
    int          latMax = 0;
    bit          rstVal = 1'b1;
    logic [31:0] mtvec = 32'h0;
    logic [31:0] mepc  = 32'h0;

    // Stream model state.
    logic [31:0] expPc = RST_PC;
    bit          holdF = 1'b0;
    logic [31:0] holdPc = 32'h0;
    logic [31:0] holdInstr = 32'h0;
    bit          redirF = 1'b0;
    logic [31:0] redirTgt = 32'h0;
    bit          invF = 1'b0;
    logic [31:0] invPc = 32'h0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a * 32'h0001_0001 + 32'h0010_0093;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step(input bit g, input bit st, input bit ps, input logic [31:0] pn,
                        input bit ex, input bit mr);
        @(posedge clk);
        #1;
        reset       = rstVal;
        imem_rvalid = pendValid && (pendDelay == 0);
        imem_rdata  = (imem_rvalid && !pendStale) ? memf(pendAddr) : 32'($urandom);
        imem_gnt    = g && !(pendValid && pendStale);
        stallE      = st;
        pcsrcE      = ps;
        pcnextE     = pn;
        excp_ena    = ex;
        mret_ena    = mr;
        csr_mtvec   = mtvec;
        csr_mepc    = mepc;
        @(negedge clk);
    endtask

    // Compare process: every cycle, outputs vs. stream model; then advance both models.
    always @(negedge clk) begin
        logic        redir;
        logic [31:0] tgt;
        redir = excp_ena | mret_ena | pcsrcE;
        tgt   = excp_ena ? csr_mtvec : (mret_ena ? csr_mepc : pcnextE);
        if (reset) begin
            chk("req_in_reset", 32'(imem_req), 32'd0);
            holdF = 1'b0;
            redirF = 1'b0;
            invF = 1'b0;
            expPc = RST_PC;
        end else begin
            if (!validE) chk("nop_when_invalid", instrE, NOP);
            chk("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
            if (redir) chk("req_blocked_on_redirect", 32'(imem_req), 32'd0);
            if (redirF) begin
                chk("redirect_kills_ex", 32'(validE), 32'd0);
                chk("redirect_target", imem_addr, redirTgt);
            end
            if (holdF) begin
                chk("stall_valid", 32'(validE), 32'd1);
                chk("stall_pc", pcE, holdPc);
                chk("stall_instr", instrE, holdInstr);
            end
            if (invF && !validE) chk("pc_hold_invalid", pcE, invPc);
            if (validE && !stallE) begin
                chk("stream_pc", pcE, expPc);
                chk("stream_instr", instrE, memf(expPc));
                expPc = expPc + 32'd4;
                consumed++;
            end
            holdF = validE && stallE && !redir;
            holdPc = pcE;
            holdInstr = instrE;
            redirF = redir;
            redirTgt = tgt;
            invF = !validE;
            invPc = pcE;
            if (redir) expPc = tgt;
        end
        if (imem_rvalid) pendValid = 1'b0;
        if (reset && pendValid) pendStale = 1'b1;
        if (imem_req && imem_gnt && !reset) begin
            chk("one_outstanding", 32'(pendValid), 32'd0);
            pendValid = 1'b1;
            pendStale = 1'b0;
            pendAddr  = imem_addr;
            pendDelay = $urandom_range(latMax, latMin);
        end else if (pendValid && pendDelay > 0) begin
            pendDelay--;
        end
    end

    initial begin
        reset = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        pcsrcE = 1'b0;
        pcnextE = 32'h0;
        excp_ena = 1'b0;
        csr_mtvec = 32'h0;
        mret_ena = 1'b0;
        csr_mepc = 32'h0;
        stallE = 1'b0;

        repeat (3) step(0, 0, 0, 32'h0, 0, 0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(validE), 32'd0);
        chk("rst_pc", pcE, 32'h0);
        chk("rst_instr", instrE, NOP);
        chk("rst_addr", imem_addr, RST_PC);

        // Back-to-back fetch after reset release
        rstVal = 1'b0;
        step(1, 0, 0, 32'h0, 0, 0);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("addr_c0", imem_addr, 32'h0);
        step(1, 0, 0, 32'h0, 0, 0);
        chk("addr_c1", imem_addr, 32'h4);
        chk("req_c1", 32'(imem_req), 32'd1);
        step(1, 0, 0, 32'h0, 0, 0);
        chk("addr_c2", imem_addr, 32'h8);
        chk("valid_c2", 32'(validE), 32'd1);
        chk("pc_c2", pcE, 32'h0);
        chk("instr_c2", instrE, 32'h0010_0093);

        // Three stalled cycles: EX frozen, one response parked, no new request
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 32'h0, 0, 0);
            chk("stall_pc_lit", pcE, 32'h4);
            chk("stall_instr_lit", instrE, 32'h0014_0097);
            chk("stall_req", 32'(imem_req), 32'd0);
        end
        step(1, 0, 0, 32'h0, 0, 0);
        chk("unstall_req", 32'(imem_req), 32'd0);
        latMin = 2;
        latMax = 2;
        step(1, 0, 0, 32'h0, 0, 0);
        chk("skid_out_valid", 32'(validE), 32'd1);
        chk("skid_out_pc", pcE, 32'h8);
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr, 32'hC);

        // Branch redirect while a request is outstanding
        step(0, 0, 1, 32'h0000_0200, 0, 0);
        step(0, 0, 0, 32'h0, 0, 0);
        chk("drop_valid", 32'(validE), 32'd0);
        chk("drop_addr", imem_addr, 32'h200);
        chk("drop_req", 32'(imem_req), 32'd0);
        latMin = 0;
        latMax = 0;
        step(1, 0, 0, 32'h0, 0, 0);
        chk("drop_exit_req", 32'(imem_req), 32'd1);
        chk("drop_exit_addr", imem_addr, 32'h200);
        step(1, 0, 0, 32'h0, 0, 0);

        // All three redirect sources at once: trap vector wins
        mtvec = 32'h0000_0100;
        mepc  = 32'h0000_0300;
        step(1, 0, 1, 32'h0000_0500, 1, 1);
        chk("target_valid", 32'(validE), 32'd1);
        chk("target_pc", pcE, 32'h200);
        chk("target_instr", instrE, 32'h0210_0293);
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        chk("prio_addr", imem_addr, 32'h100);
        chk("prio_valid", 32'(validE), 32'd0);

        // Grant withheld at the top of the address space, then wrap
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 32'h0, 0, 0);
            chk("nogrant_req", 32'(imem_req), 32'd1);
            chk("nogrant_addr", imem_addr, 32'hFFFF_FFFC);
        end
        step(1, 0, 0, 32'h0, 0, 0);
        chk("wrap_req", 32'(imem_req), 32'd1);
        step(1, 0, 0, 32'h0, 0, 0);
        chk("wrap_addr", imem_addr, 32'h0);
        step(1, 0, 0, 32'h0, 0, 0);
        chk("wrap_pc", pcE, 32'hFFFF_FFFC);
        chk("wrap_instr", instrE, 32'h000C_008F);

        // Randomized traffic: grants, latencies, stalls, redirects and resets
        latMin = 0;
        latMax = 3;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            int  r;
            bit  g;
            bit  st;
            r  = int'($urandom_range(99, 0));
            g  = ($urandom_range(9, 0) < 7);
            st = ($urandom_range(9, 0) < 3);
            if ($urandom_range(49, 0) == 0) mtvec = 32'($urandom) & 32'hFFFF_FFFC;
            if ($urandom_range(49, 0) == 0) mepc  = 32'($urandom) & 32'hFFFF_FFFC;
            rstVal = ($urandom_range(399, 0) == 0);
            step(g, st, (r >= 2 && r < 5), 32'($urandom) & 32'hFFFF_FFFC, (r == 0), (r == 1));
        end
        rstVal = 1'b0;
        chk("forward_progress", 32'(consumed >= 300), 32'd1);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

// File: doc/cpu6_fetch.md
CPU6_FETCH -- requirements
Module: cpu6_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), the instruction driven on instrE when no valid instruction is present.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_req  output  1  fetch request valid.
REQ-006 SHALL have port imem_addr  output  32  fetch address (word aligned).
REQ-007 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  response valid; at least 1 cycle after gnt; in order.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-010 SHALL have port pcsrcE  input  1  EX redirect (branch/jump).
REQ-011 SHALL have port pcnextE  input  32  EX redirect target.
REQ-012 SHALL have port excp_ena  input  1  trap/interrupt redirect.
REQ-013 SHALL have port csr_mtvec  input  32  trap target.
REQ-014 SHALL have port mret_ena  input  1  mret redirect.
REQ-015 SHALL have port csr_mepc  input  32  mret target.
REQ-016 SHALL have port stallE  input  1  EX cannot accept a new instruction.
REQ-017 SHALL have port pcE  output  32  PC of instruction in EX.
REQ-018 SHALL have port instrE  output  32  instruction in EX.
REQ-019 SHALL have port validE  output  1  instrE/pcE hold a real instruction.

Function
REQ-020 SHALL hold a fetch_pc register; imem_addr = fetch_pc at all times.
REQ-021 SHALL use FSM states IDLE (nothing outstanding), WAIT (one request outstanding), DROP (outstanding response to be discarded); at most one request outstanding.
REQ-022 SHALL assert imem_req when skid buffer empty, no redirect this cycle, and (state==IDLE or imem_rvalid).
REQ-023 SHALL on imem_req & imem_gnt go to WAIT and set fetch_pc = fetch_pc + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); req & ~gnt keeps address and state.
REQ-024 SHALL in WAIT on imem_rvalid without new grant go to IDLE; with new grant stay WAIT (back-to-back, 1 instr/cycle when rvalid follows gnt by 1).
REQ-025 SHALL capture an accepted response {fetched pc, imem_rdata} into the EX register on the next edge when validE==0 or stallE==0, else into a one-entry skid buffer.
REQ-026 SHALL move skid buffer into the EX register when stallE==0; EX register holds unchanged while stallE==1.
REQ-027 SHALL drive instrE = NOP_INSTR whenever validE==0; pcE holds last value.
REQ-028 SHALL redirect with priority excp_ena > mret_ena > pcsrcE; target csr_mtvec / csr_mepc / pcnextE loaded into fetch_pc next edge.
REQ-029 SHALL on redirect clear validE and skid buffer next edge, overriding stallE.
REQ-030 SHALL on redirect while a request is outstanding and imem_rvalid==0 enter DROP; redirect in the same cycle as imem_rvalid discards that response and enters IDLE.
REQ-031 SHALL in DROP discard the next imem_rvalid (no EX/buffer update) and go to IDLE; imem_req may be raised that cycle per REQ-022.
REQ-032 SHALL treat a second redirect during DROP as updating fetch_pc only, staying in DROP.

Reset
REQ-033 SHALL on reset set fetch_pc=RESET_PC, state=IDLE, validE=0, pcE=0, skid buffer empty; imem_req=0 during reset and asserted first cycle after reset deasserts.
REQ-034 SHALL on reset mid-operation abandon any outstanding request; a later imem_rvalid in IDLE is ignored.

Verification
REQ-035 Reset release, gnt immediate, rvalid 1 cycle later, rdata 32'h0010_0093 -> imem_addr 0,4,8 on consecutive cycles; validE=1, pcE=0, instrE=32'h0010_0093 two cycles after first req.
REQ-036 stallE=1 for 3 cycles with validE=1 -> pcE/instrE constant, one response held in skid buffer, imem_req=0 until stallE drops; no instruction lost or duplicated.
REQ-037 pcsrcE=1, pcnextE=32'h0000_0200 while request outstanding -> validE=0 next cycle, DROP entered, stale rdata discarded, next imem_addr=32'h200.
REQ-038 excp_ena, mret_ena, pcsrcE same cycle, mtvec=32'h100, mepc=32'h300 -> next imem_addr=32'h100.
REQ-039 fetch_pc=32'hFFFF_FFFC granted -> next imem_addr=0; imem_gnt held low 4 cycles -> imem_addr/imem_req stable, state unchanged.
